// File: rtl/ifu_pkg.sv
// Shared types for the instruction-fetch unit: FSM state encoding, queue entry layout and
// the fetch-step helper. Used by ifu_fifo and ifu_prefetch.
package ifu_pkg;

  localparam int unsigned IFU_WIDTH  = 32;
  localparam int unsigned INST_BYTES = IFU_WIDTH / 8;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } ifu_state_t;

  typedef struct packed {
    logic [IFU_WIDTH-1:0] inst;
    logic [IFU_WIDTH-1:0] pc;
    logic                 fault;
  } ifu_entry_t;

  function automatic int unsigned inst_bytes(input int unsigned width);
    return width / 8;
  endfunction

endpackage

// File: rtl/ifu_fifo.sv
// Synchronous prefetch queue: DEPTH entries (power of 2), flush has priority over push/pop,
// simultaneous push+pop allowed when full. Head output holds the last popped entry while empty.
module ifu_fifo
  import ifu_pkg::*;
#(
  parameter type         T     = ifu_entry_t,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_flush,
  input  logic             i_push,
  input  T                 i_data,
  input  logic             i_pop,
  output T                 o_data,
  output logic [CNT_W-1:0] o_count,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  T                 r_mem [DEPTH];
  T                 r_hold;
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign w_pop   = i_pop & ~o_empty & ~i_flush;
  assign w_push  = i_push & (~o_full | w_pop) & ~i_flush;
  assign o_data  = o_empty ? r_hold : r_mem[r_rptr];
  assign o_count = r_count;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_hold  <= '0;
    end else if (i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_hold  <= o_data;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
        r_hold <= r_mem[r_rptr];
      end
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/ifu_prefetch.sv
// Instruction-fetch unit with credit-limited prefetch queue and redirect flush.
// Optional IFU_PERF_CNT_EN adds perf_fetch_cnt / perf_stall_cnt outputs.
module ifu_prefetch
  import ifu_pkg::*;
#(
  parameter int unsigned      WIDTH    = 32,
  parameter int unsigned      DEPTH    = 4,
  parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(32'h8000_0000)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               redirect_valid,
  input  logic [WIDTH-1:0]   redirect_pc,
  output logic               mem_req_valid,
  output logic [WIDTH-1:0]   mem_req_addr,
  input  logic               mem_req_ready,
  input  logic               mem_rsp_valid,
  input  logic [WIDTH-1:0]   mem_rsp_data,
  input  logic               mem_rsp_err,
  output logic               ifu_valid,
  output logic [2*WIDTH-1:0] ifu_data,
  output logic               ifu_fault,
`ifdef IFU_PERF_CNT_EN
  output logic [31:0]        perf_fetch_cnt,
  output logic [31:0]        perf_stall_cnt,
`endif
  input  logic               idu_ready
);

  localparam int unsigned      CNT_W = $clog2(DEPTH + 1);
  localparam logic [WIDTH-1:0] STEP  = WIDTH'(inst_bytes(WIDTH));

  typedef struct packed {
    logic [WIDTH-1:0] inst;
    logic [WIDTH-1:0] pc;
    logic             fault;
  } entry_t;

  ifu_state_t       r_state;
  ifu_state_t       w_state_nxt;
  logic [WIDTH-1:0] r_fetch_pc;
  logic [WIDTH-1:0] r_rsp_pc;
  logic [CNT_W-1:0] r_inflight;
  logic [CNT_W-1:0] r_drop;
  logic [CNT_W-1:0] w_count;
  logic [CNT_W:0]   w_credit;
  logic             w_req_valid;
  logic             w_req_fire;
  logic             w_rsp_fire;
  logic             w_push;
  logic             w_pop;
  logic             w_full;
  logic             w_empty;
  entry_t           w_push_data;
  entry_t           w_head;

  // Queued plus in-flight fetches (including ones pending drop) must fit in the queue.
  assign w_credit = {1'b0, w_count} + {1'b0, r_inflight};

  always_comb begin
    w_state_nxt = r_state;
    w_req_valid = 1'b0;
    unique case (r_state)
      S_IDLE: if (start) w_state_nxt = S_RUN;
      S_RUN: begin
        if (!start) w_state_nxt = S_IDLE;
        w_req_valid = start && (w_credit < (CNT_W+1)'(DEPTH)) && !redirect_valid;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign mem_req_valid = w_req_valid;
  assign mem_req_addr  = r_fetch_pc;
  assign w_req_fire    = w_req_valid & mem_req_ready;
  assign w_rsp_fire    = mem_rsp_valid;
  assign w_push        = w_rsp_fire && (r_drop == '0) && !redirect_valid;
  assign w_pop         = ifu_valid & idu_ready;
  assign w_push_data   = '{inst: mem_rsp_data, pc: r_rsp_pc, fault: mem_rsp_err};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_fetch_pc <= RESET_PC;
      r_rsp_pc   <= RESET_PC;
      r_inflight <= '0;
      r_drop     <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (redirect_valid) begin
        // Everything still outstanding belongs to the old stream, minus the response landing now.
        r_fetch_pc <= redirect_pc;
        r_rsp_pc   <= redirect_pc;
        r_drop     <= r_drop + r_inflight - CNT_W'(w_rsp_fire);
        r_inflight <= r_inflight - CNT_W'(w_rsp_fire);
      end else begin
        if (w_req_fire) r_fetch_pc <= r_fetch_pc + STEP;
        if (w_push) r_rsp_pc <= r_rsp_pc + STEP;
        if (w_rsp_fire && (r_drop != '0)) r_drop <= r_drop - 1'b1;
        r_inflight <= r_inflight + CNT_W'(w_req_fire) - CNT_W'(w_rsp_fire);
      end
    end
  end

  ifu_fifo #(
    .T     (entry_t),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_flush (redirect_valid),
    .i_push  (w_push),
    .i_data  (w_push_data),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign ifu_valid = ~w_empty;
  assign ifu_data  = {w_head.inst, w_head.pc};
  assign ifu_fault = ~w_empty & w_head.fault;

`ifdef IFU_PERF_CNT_EN
  logic [31:0] r_perf_fetch;
  logic [31:0] r_perf_stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_fetch <= '0;
      r_perf_stall <= '0;
    end else begin
      if (w_push) r_perf_fetch <= r_perf_fetch + 32'd1;
      if (ifu_valid && !idu_ready) r_perf_stall <= r_perf_stall + 32'd1;
    end
  end

  assign perf_fetch_cnt = r_perf_fetch;
  assign perf_stall_cnt = r_perf_stall;
`endif

  ap_credit: assert property (@(posedge clk) disable iff (!rst_n)
    w_credit <= (CNT_W+1)'(DEPTH));
  ap_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(w_full && w_push && !w_pop));

endmodule

// File: tb/tb_ifu_prefetch.sv
// Scoreboard bench for ifu_prefetch: a memory model records accepted fetches as expected
// IDU entries; a monitor pops and compares on every IDU handshake.
module tb_ifu_prefetch;

  localparam logic [31:0] RST_PC = 32'h8000_0000;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        fault;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic        mem_req_ready = 1'b0;
  logic        mem_rsp_valid = 1'b0;
  logic [31:0] mem_rsp_data = '0;
  logic        mem_rsp_err = 1'b0;
  logic        ifu_valid;
  logic [63:0] ifu_data;
  logic        ifu_fault;
  logic        idu_ready = 1'b0;

  exp_t        sb_q[$];
  logic [31:0] pend_q[$];
  logic [31:0] acc_log[$];
  logic        hold = 1'b0;
  logic [31:0] err_addr = 32'hFFFF_FFFF;
  int          fires = 0;
  int          faults_seen = 0;
  int          n_tests = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  ifu_prefetch #(
    .WIDTH    (32),
    .DEPTH    (4),
    .RESET_PC (RST_PC)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .mem_req_valid  (mem_req_valid),
    .mem_req_addr   (mem_req_addr),
    .mem_req_ready  (mem_req_ready),
    .mem_rsp_valid  (mem_rsp_valid),
    .mem_rsp_data   (mem_rsp_data),
    .mem_rsp_err    (mem_rsp_err),
    .ifu_valid      (ifu_valid),
    .ifu_data       (ifu_data),
    .ifu_fault      (ifu_fault),
    .idu_ready      (idu_ready)
  );

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Memory: responds one cycle after acceptance, in order, unless held.
  initial begin
    logic [31:0] a;
    forever begin
      @(negedge clk);
      #1;
      mem_rsp_valid = 1'b0;
      mem_rsp_err   = 1'b0;
      if (!rst_n) begin
        pend_q.delete();
      end else begin
        if (!hold && pend_q.size() > 0) begin
          a = pend_q.pop_front();
          mem_rsp_valid = 1'b1;
          mem_rsp_data  = inst_of(a);
          mem_rsp_err   = (a == err_addr);
        end
        if (mem_req_valid && mem_req_ready) begin
          pend_q.push_back(mem_req_addr);
          acc_log.push_back(mem_req_addr);
          fires++;
          sb_q.push_back('{inst: inst_of(mem_req_addr), pc: mem_req_addr,
                           fault: (mem_req_addr == err_addr)});
        end
      end
    end
  end

  // Monitor: compares every accepted head against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && ifu_valid && idu_ready && !redirect_valid) begin
        if (ifu_fault) faults_seen++;
        if (sb_q.size() == 0) begin
          check("unexpected_ifu_out", ifu_data, 64'h0);
        end else begin
          e = sb_q.pop_front();
          check("ifu_pc", {32'h0, ifu_data[31:0]}, {32'h0, e.pc});
          check("ifu_inst", {32'h0, ifu_data[63:32]}, {32'h0, e.inst});
          check("ifu_fault", {63'h0, ifu_fault}, {63'h0, e.fault});
        end
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_valid"}, {63'h0, mem_req_valid}, 64'h0);
    check({tag, "_req_addr"}, {32'h0, mem_req_addr}, {32'h0, RST_PC});
    check({tag, "_ifu_valid"}, {63'h0, ifu_valid}, 64'h0);
    check({tag, "_ifu_data"}, ifu_data, 64'h0);
    check({tag, "_ifu_fault"}, {63'h0, ifu_fault}, 64'h0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    start = 1'b0;
    redirect_valid = 1'b0;
    idu_ready = 1'b0;
    mem_req_ready = 1'b0;
    hold = 1'b0;
    sb_q.delete();
    pend_q.delete();
    acc_log.delete();
    fires = 0;
    faults_seen = 0;
    cyc(2);
    rst_n = 1'b1;
  endtask

  task automatic wait_drain(input string name);
    int k;
    k = 0;
    idu_ready = 1'b1;
    start = 1'b0;
    while ((sb_q.size() != 0 || pend_q.size() != 0) && k < 60) begin
      cyc(1);
      k++;
    end
    cyc(2);
    check(name, 64'(sb_q.size()), 64'h0);
  endtask

  task automatic wait_fires(input int n, input string name);
    int k;
    k = 0;
    while (fires < n && k < 40) begin
      cyc(1);
      k++;
    end
    check(name, 64'(fires), 64'(n));
  endtask

  task automatic wait_valid_pc(input logic [31:0] pc, input string name);
    int k;
    k = 0;
    while (!ifu_valid && k < 40) begin
      cyc(1);
      k++;
    end
    check(name, {32'h0, ifu_data[31:0]}, {32'h0, pc});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    do_reset();
    rst_n = 1'b0;
    cyc(1);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // 1: sequential stream
    start = 1'b1; idu_ready = 1'b1; mem_req_ready = 1'b1;
    cyc(12);
    wait_drain("t1_drain");
    for (int i = 0; i < 3; i++)
      check("t1_addr", (i < acc_log.size()) ? {32'h0, acc_log[i]} : 64'hDEAD,
            {32'h0, RST_PC + 32'(4 * i)});

    // 2: backpressure fills exactly DEPTH, then one request per pop
    do_reset();
    start = 1'b1; mem_req_ready = 1'b1;
    cyc(12);
    check("t2_fires_full", 64'(fires), 64'd4);
    check("t2_req_stopped", {63'h0, mem_req_valid}, 64'h0);
    check("t2_valid_held", {63'h0, ifu_valid}, 64'h1);
    check("t2_head_pc", {32'h0, ifu_data[31:0]}, {32'h0, RST_PC});
    for (int i = 0; i < 2; i++) begin
      idu_ready = 1'b1;
      cyc(1);
      idu_ready = 1'b0;
      cyc(6);
      check("t2_fires_per_pop", 64'(fires), 64'(5 + i));
      check("t2_req_stopped2", {63'h0, mem_req_valid}, 64'h0);
    end
    wait_drain("t2_drain");

    // 3: redirect with three fetches in flight
    do_reset();
    hold = 1'b1; mem_req_ready = 1'b1; idu_ready = 1'b1; start = 1'b1;
    wait_fires(3, "t3_three_inflight");
    mem_req_ready = 1'b0;
    cyc(2);
    check("t3_fires", 64'(fires), 64'd3);
    check("t3_req_held_valid", {63'h0, mem_req_valid}, 64'h1);
    check("t3_req_held_addr", {32'h0, mem_req_addr}, {32'h0, RST_PC + 32'hC});
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0100;
    sb_q.delete();
    hold = 1'b0; mem_req_ready = 1'b1;
    cyc(1);
    redirect_valid = 1'b0;
    check("t3_flushed", {63'h0, ifu_valid}, 64'h0);
    check("t3_new_addr", {32'h0, mem_req_addr}, 64'h8000_0100);
    cyc(1);
    check("t3_drop1", {63'h0, ifu_valid}, 64'h0);
    cyc(1);
    check("t3_drop2", {63'h0, ifu_valid}, 64'h0);
    wait_valid_pc(32'h8000_0100, "t3_first_pc");
    wait_drain("t3_drain");

    // 4: redirect coinciding with a response and a pop attempt
    do_reset();
    hold = 1'b1; mem_req_ready = 1'b1; start = 1'b1;
    wait_fires(4, "t4_four_inflight");
    hold = 1'b0;
    cyc(2);
    check("t4_queued", {63'h0, ifu_valid}, 64'h1);
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0200; idu_ready = 1'b1;
    sb_q.delete();
    cyc(1);
    redirect_valid = 1'b0;
    check("t4_no_stale_valid", {63'h0, ifu_valid}, 64'h0);
    cyc(1);
    check("t4_dropped", {63'h0, ifu_valid}, 64'h0);
    wait_valid_pc(32'h8000_0200, "t4_first_pc");
    wait_drain("t4_drain");

    // 5: access fault on the second fetch only
    do_reset();
    err_addr = 32'h8000_0004;
    start = 1'b1; idu_ready = 1'b1; mem_req_ready = 1'b1;
    cyc(10);
    wait_drain("t5_drain");
    check("t5_fault_count", 64'(faults_seen), 64'd1);
    err_addr = 32'hFFFF_FFFF;

    // 6: asynchronous reset mid-stream
    do_reset();
    start = 1'b1; idu_ready = 1'b1; mem_req_ready = 1'b1;
    cyc(6);
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("t6_async");
    sb_q.delete();
    pend_q.delete();
    start = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    acc_log.delete();
    start = 1'b1;
    cyc(5);
    check("t6_restart_addr", (acc_log.size() > 0) ? {32'h0, acc_log[0]} : 64'hDEAD,
          {32'h0, RST_PC});
    wait_drain("t6_drain");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
